// File: rtl/pll_i2s_ratio.sv
// I2S bit-clock rate converter: passes NUM of every DEN inclk0 pulses.
// Swallowed pulses are spread evenly; the gate only changes while inclk0 is low.
module pll_i2s_ratio #(
  parameter int NUM         = 4,
  parameter int DEN         = 5,
  parameter int LOCK_CYCLES = 32
) (
  input  logic inclk0,
  input  logic reset_n,
  output logic c0,
  output logic locked
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_CYCLES);
  localparam logic [8:0] NUM_W  = 9'(NUM);
  localparam logic [8:0] DEN_W  = 9'(DEN);

  logic [7:0] lcnt;
  logic [7:0] acc;
  logic [7:0] acc_nxt;
  logic [8:0] sum;
  logic       en;
  logic       en_nxt;
  logic       en_l;

  always_ff @(posedge inclk0 or negedge reset_n) begin
    if (!reset_n) begin
      lcnt   <= 8'd0;
      locked <= 1'b0;
    end else if (lcnt < LOCK_N) begin
      lcnt <= lcnt + 8'd1;
      if (lcnt == LOCK_N - 8'd1)
        locked <= 1'b1;
    end
  end

  always_comb begin
    sum     = {1'b0, acc} + NUM_W;
    en_nxt  = 1'b0;
    acc_nxt = sum[7:0];
    if (sum >= DEN_W) begin
      en_nxt  = 1'b1;
      acc_nxt = 8'(sum - DEN_W);
    end
  end

  always_ff @(posedge inclk0 or negedge reset_n) begin
    if (!reset_n) begin
      acc <= 8'd0;
      en  <= 1'b0;
    end else if (!locked) begin
      acc <= 8'd0;
      en  <= 1'b0;
    end else begin
      acc <= acc_nxt;
      en  <= en_nxt;
    end
  end

  // Latch on the falling edge so the AND gate never sees a change mid-pulse.
  always_ff @(negedge inclk0 or negedge reset_n) begin
    if (!reset_n)
      en_l <= 1'b0;
    else
      en_l <= en;
  end

  assign c0 = inclk0 & en_l;

endmodule

// File: tb/tb_pll_i2s_ratio.sv
// Directed bench for pll_i2s_ratio at 4/5, 3/8 and 5/5.
// Three instances share inclk0 and reset_n.
module tb_pll_i2s_ratio;

  logic inclk0;
  logic reset_n;
  logic c0_a, c0_b, c0_c;
  logic lk_a, lk_b, lk_c;

  int total = 0;
  int bad   = 0;
  int rise_cnt = 0;
  int wbad  = 0;
  time t_rise = 0;
  logic [7:0] pat8 = 8'b1010_0100;

  pll_i2s_ratio #(.NUM(4), .DEN(5), .LOCK_CYCLES(32)) u_a (
    .inclk0(inclk0), .reset_n(reset_n), .c0(c0_a), .locked(lk_a));
  pll_i2s_ratio #(.NUM(3), .DEN(8), .LOCK_CYCLES(32)) u_b (
    .inclk0(inclk0), .reset_n(reset_n), .c0(c0_b), .locked(lk_b));
  pll_i2s_ratio #(.NUM(5), .DEN(5), .LOCK_CYCLES(32)) u_c (
    .inclk0(inclk0), .reset_n(reset_n), .c0(c0_c), .locked(lk_c));

  initial inclk0 = 1'b0;
  always #5 inclk0 = ~inclk0;

  always @(posedge c0_a) begin
    rise_cnt++;
    t_rise = $time;
  end

  always @(negedge c0_a)
    if (reset_n && ($time - t_rise != 5)) wbad++;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_a(input int n);
    return (n >= 35) && ((n - 34) % 5 != 0);
  endfunction

  function automatic logic exp_b(input int n);
    if (n < 34) return 1'b0;
    return pat8[(n - 34) % 8];
  endfunction

  task automatic run(input int last, input bit cnt_en);
    int base;
    base = 0;
    for (int n = 1; n <= last; n++) begin
      @(posedge inclk0); #2;
      chk("locked_a", lk_a, n >= 32);
      chk("locked_b", lk_b, n >= 32);
      chk("locked_c", lk_c, n >= 32);
      chk("c0_4_5", c0_a, exp_a(n));
      chk("c0_3_8", c0_b, exp_b(n));
      chk("c0_5_5", c0_c, n >= 34);
      @(negedge inclk0); #2;
      chk("c0_lo_a", c0_a, 1'b0);
      chk("c0_lo_b", c0_b, 1'b0);
      chk("c0_lo_c", c0_c, 1'b0);
      if (cnt_en && n == 34) base = rise_cnt;
      if (cnt_en && n == 1034)
        chki("rises_1000", rise_cnt - base, 800);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (5) begin
      @(posedge inclk0); #2;
      chk("rst_c0_a", c0_a, 1'b0);
      chk("rst_c0_c", c0_c, 1'b0);
      chk("rst_lock", lk_a, 1'b0);
    end
    @(negedge inclk0); #2;
    reset_n = 1'b1;
    run(1040, 1'b1);

    @(posedge inclk0); #2;
    chk("pre_rst_c0", c0_a, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_c0_a", c0_a, 1'b0);
    chk("async_c0_c", c0_c, 1'b0);
    chk("async_lock", lk_a, 1'b0);
    repeat (3) @(posedge inclk0);
    @(negedge inclk0); #2;
    reset_n = 1'b1;
    run(60, 1'b0);

    chki("pulse_width", wbad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
